crc_frame_tx: RTL
=================

Name: crc_frame_tx

Overview:
- Transmit-side framing stage placed directly upstream of the parallel CCITT CRC engine.
- Accepts a byte stream with end-of-frame markers and forwards each byte downstream.
- Drives the CRC engine's enable/init/data inputs, then appends the engine's 16-bit CRC result as two trailing bytes, MSB first.
- Also enforces a maximum frame length and counts completed frames.

Parameters:
- MAX_LEN, 1024, maximum payload bytes per frame (range 1..65535). The byte that reaches this count is treated as the last byte.
- CNT_W, 16, width of the frame_count status output.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream payload byte.
- in_last  input  1  marks the final payload byte of the frame.
- in_ready  output  1  block accepts the byte this cycle.
- out_valid  output  1  downstream byte valid (registered).
- out_data  output  8  downstream byte (registered).
- out_last  output  1  high on the CRC low byte only.
- out_ready  input  1  downstream accepts.
- crc_enable  output  1  to CRC engine enable.
- crc_init  output  1  to CRC engine init.
- crc_data  output  8  to CRC engine data_in.
- crc_in  input  16  from CRC engine crc_out.
- err_len  output  1  one-cycle pulse on forced frame truncation.
- frame_count  output  CNT_W  completed frames, wraps.

Behaviour:
- Reset (reset=0, asynchronous), all outputs go to these values:
  - state=INIT; out_valid=0, out_data=0, out_last=0.
  - err_len=0, frame_count=0, byte counter=0.
- States: INIT, DATA, CRC_HI, CRC_LO.
- slot_free = !out_valid || out_ready. The output register is loaded only when slot_free; otherwise it holds and out_valid clears on out_ready.
- INIT (exactly 1 cycle):
  - crc_enable=1, crc_init=1, in_ready=0.
  - Next state is DATA.
  - The CRC engine register reads 0xFFFF from the following cycle.
- DATA:
  - in_ready = slot_free. Accept = in_valid && in_ready.
  - On accept, combinationally in the same cycle: crc_enable=1, crc_init=0, crc_data=in_data. The engine absorbs the byte at that edge.
  - On accept, registered: out_data<=in_data, out_last<=0, out_valid<=1, counter+1.
  - On accept with in_last=1, or with counter==MAX_LEN-1: counter<=0, go to CRC_HI.
  - If the transition was caused by the length limit without in_last, err_len pulses for 1 cycle on the following cycle.
  - With no accept, crc_enable=0 and crc_data=0.
- Upstream bytes arriving after a forced truncation and before their own in_last are treated as a new frame.
- CRC_HI:
  - in_ready=0, crc_enable=0.
  - When slot_free: out_data<=crc_in[15:8], out_last<=0, out_valid<=1, go to CRC_LO.
  - crc_in is stable here because the engine is not enabled.
- CRC_LO:
  - When slot_free: out_data<=crc_in[7:0], out_last<=1, out_valid<=1, frame_count+1 (wraps at 2^CNT_W), go to INIT.
- Frame overhead: 3 cycles per frame (CRC_HI, CRC_LO, INIT) with out_ready held high. The first payload byte appears on out_data 1 cycle after acceptance.
- No combinational path from out_ready to out_valid/out_data. in_ready does depend combinationally on out_ready.
- Downstream stall: out_valid and out_data are held stable until out_ready; nothing is dropped or duplicated.
- Simultaneous out_ready and new accept: the register reloads and out_valid stays 1 (full throughput).
- Reset mid-frame: the partial frame is discarded. Restart in INIT re-initialises the engine, so there is no CRC carry-over.
- crc_init is never asserted outside INIT.

Test Plan:
- Bench CRC engine is a behavioural CCITT model (poly 0x1021, init 0xFFFF, non-reflected, no output XOR). Frame "123456789" (0x31..0x39, in_last on 0x39), out_ready=1 → out sequence 0x31..0x39, 0x29, 0xB1; out_last only on 0xB1; frame_count=1.
- Single-byte frame 0x00 → out 0x00, 0xE1, 0xF0; INIT cycle shows crc_enable=crc_init=1; second frame 0x00 again yields 0xE1F0 (init verified).
- Random out_ready (50%) over 20 random frames → byte stream matches model exactly; out_data stable while out_valid && !out_ready; no in_ready while in CRC_HI/CRC_LO/INIT.
- MAX_LEN=4, feed 6 bytes with in_last on 6th → frame 1 = 4 bytes + CRC with err_len pulse; frame 2 = bytes 5,6 + CRC; frame_count=2.
- Assert reset low after 3 bytes of a frame → outputs return to reset values immediately; a new frame 0x00 then yields 0xE1F0.
- CNT_W=2, send 5 one-byte frames → frame_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/crc_frame_tx.sv
// crc_frame_tx: transmit framing stage in front of a parallel CCITT CRC engine.
// Forwards payload bytes through a one-deep output register, steers the CRC
// engine's init/enable/data inputs, then appends the engine's 16-bit result as
// two trailing bytes (high byte first). Enforces a maximum frame length and
// counts completed frames.
module crc_frame_tx #(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             crc_enable,
  output logic             crc_init,
  output logic [7:0]       crc_data,
  input  logic [15:0]      crc_in,
  output logic             err_len,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {
    S_INIT,
    S_DATA,
    S_CRC_HI,
    S_CRC_LO
  } state_e;

  // Counter value of the byte that is forced to close the frame.
  localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             err_len_q, err_len_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             slot_free;
  logic             accept;

  // The output register may take a new byte when empty or being drained now.
  assign slot_free = !out_valid_q || out_ready;

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign err_len     = err_len_q;
  assign frame_count = frame_count_q;

  // Next-state, output-register load and CRC engine steering.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    err_len_d     = 1'b0;
    frame_count_d = frame_count_q;
    cnt_d         = cnt_q;
    in_ready      = 1'b0;
    accept        = 1'b0;
    crc_enable    = 1'b0;
    crc_init      = 1'b0;
    crc_data      = 8'h00;

    case (state_q)
      S_INIT: begin
        // One cycle to preset the engine to 0xFFFF before the first byte.
        crc_enable = 1'b1;
        crc_init   = 1'b1;
        state_d    = S_DATA;
      end

      S_DATA: begin
        in_ready = slot_free;
        accept   = in_valid && slot_free;
        if (accept) begin
          crc_enable  = 1'b1;
          crc_data    = in_data;
          out_data_d  = in_data;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          if (in_last || (cnt_q == LAST_IDX)) begin
            // A length-forced close without in_last is a truncation.
            cnt_d     = 16'd0;
            err_len_d = !in_last;
            state_d   = S_CRC_HI;
          end
        end
      end

      S_CRC_HI: begin
        // Engine is idle here, so crc_in is stable for both CRC bytes.
        if (slot_free) begin
          out_data_d  = crc_in[15:8];
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_CRC_LO;
        end
      end

      S_CRC_LO: begin
        if (slot_free) begin
          out_data_d    = crc_in[7:0];
          out_last_d    = 1'b1;
          out_valid_d   = 1'b1;
          frame_count_d = frame_count_q + CNT_W'(1);
          state_d       = S_INIT;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_INIT;
      out_valid_q   <= 1'b0;
      out_data_q    <= 8'h00;
      out_last_q    <= 1'b0;
      err_len_q     <= 1'b0;
      frame_count_q <= '0;
      cnt_q         <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      err_len_q     <= err_len_d;
      frame_count_q <= frame_count_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule
